fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction fetch stage between the program counter and decode. Each cycle it issues an instruction-memory read for the address the PC presents and captures the returned word with its address in a small FIFO. It presents that FIFO to decode with a valid/ready handshake, and back-pressures the PC through its halt input when the buffer cannot absorb another fetch. On a taken branch the PC's flush drops all stale instructions, and the fetch issued in the flush cycle (the branch target) is kept.

## Interface
- DEPTH, 2: FIFO entries; power of two, 2..8.
- i_clk  in  1  global clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_imem_raddr  in  32  fetch address from PC (its o_imem_raddr).
- o_imem_ren  out  1  read request for i_imem_raddr this cycle.
- i_imem_rdata  in  32  instruction for the request issued the previous cycle (synchronous memory, 1-cycle latency).
- i_flush  in  1  taken branch (PC o_flush); discard buffered and in-flight instructions.
- o_pc_hold  out  1  to PC i_halt; PC must not advance.
- o_valid  out  1  o_inst/o_pc hold a valid instruction.
- i_ready  in  1  decode accepts this cycle.
- o_inst  out  32  instruction to decode.
- o_pc  out  32  address of o_inst.

## Operation
- State:
  - FIFO of DEPTH {pc, inst} entries with rd/wr pointers and count (0..DEPTH).
  - In-flight register {req_vld, req_pc}.
- pop = o_valid & i_ready.
- o_valid = (count != 0) & !i_flush. When i_flush is high, the head is hidden and is not popped.
- o_pc_hold = !i_flush & (count + req_vld - pop >= DEPTH). Compute the sum at 4 bits wide. There is a combinational path from i_ready.
- o_imem_ren = i_rst_n & !o_pc_hold.
- On each edge without flush:
  - If req_vld, write {req_pc, i_imem_rdata} into the FIFO.
  - If pop, advance rd.
  - Simultaneous write and pop leaves count unchanged.
  - The credit rule guarantees no write occurs when full.
- In-flight update: req_vld <= o_imem_ren; req_pc <= i_imem_raddr.
- On an edge with i_flush:
  - FIFO is emptied (count 0, pointers equal).
  - Landing data from the older request is discarded.
  - The request issued in the flush cycle is kept: req_vld <= 1, req_pc <= target.
- Pointers wrap modulo DEPTH.
- Reset (any time, including mid-stream):
  - count 0, pointers 0, req_vld 0, req_pc 0.
  - o_valid 0, o_pc_hold 0, o_imem_ren 0 while reset is asserted.
  - o_inst/o_pc read 0 (storage cleared).
  - First request is issued in the first cycle after deassertion.

## Timing
- Fetch latency: address issued in cycle t, data lands at t+1, o_valid at t+2.
- Streaming with i_ready held high: one instruction per cycle at DEPTH=2, o_pc_hold stays low.
- With i_ready low, o_pc_hold rises once count + in-flight reaches DEPTH. No instruction is dropped or duplicated.
- Flush in cycle t:
  - o_valid low in cycle t and t+1.
  - Target instruction valid in cycle t+2.
- o_inst/o_pc are stable while o_valid & !i_ready.

## Configuration
- FETCH_BUF_BYPASS_EN defined:
  - When the FIFO is empty and req_vld is high with no flush, the landing word is presented directly: o_valid=1, o_inst=i_imem_rdata, o_pc=req_pc.
  - If accepted, it is not written. Latency drops to 1 cycle.
  - o_pc_hold is unchanged.
- Not defined: always registered, 2-cycle latency.

## Structure
- Package fetch_pkg:
  - FETCH_DEPTH_DEFAULT.
  - fetch_entry_t {pc[31:0], inst[31:0]}.
  - Pointer-width function for DEPTH.
- Sub-module fetch_fifo: storage, pointers, count, flush-clear.
- fetch_buffer owns the in-flight register, credit/hold logic, and the bypass mux.

## Test plan
- Reset: i_rst_n low mid-stream with count=2 -> o_valid=0, o_pc_hold=0, o_imem_ren=0 immediately; first request after release at RESET_ADDR.
- Streaming: addresses 0x0,0x4,0x8, mem[a]=0xA000_0000+a, i_ready=1 -> o_pc 0x0,0x4,0x8 on consecutive cycles starting t+2, o_pc_hold never high.
- Backpressure: i_ready=0 from cycle 3 -> o_pc_hold high when count+in-flight=2; release -> sequence continues without gaps/duplicates.
- Flush with full FIFO and request in flight, target 0x40 -> o_valid low 2 cycles, then o_pc=0x40; stale 0x8/0xC never presented.
- Back-to-back flushes in cycles t and t+1 (targets 0x40, 0x80) -> only 0x80 presented, at t+3.
- With FETCH_BUF_BYPASS_EN: single fetch at 0x10 into empty buffer -> o_valid with o_pc=0x10 at t+1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch buffer.
package fetch_pkg;

  localparam int FETCH_DEPTH_DEFAULT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Pointer width for a power-of-two depth; a 2-entry FIFO still needs one bit.
  function automatic int fetch_ptr_w(input int depth);
    int w;
    w = 1;
    for (int i = 2; i < depth; i = i * 2) w++;
    return w;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction FIFO of {pc, inst} entries with a single-cycle flush clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_inst,
  input  logic        rd_en,
  output logic [31:0] head_pc,
  output logic [31:0] head_inst,
  output logic [3:0]  count
);

  localparam int PW = fetch_ptr_w(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  assign head_pc   = mem[rd_ptr].pc;
  assign head_inst = mem[rd_ptr].inst;

  // Storage is cleared on reset so the head reads zero; a flush only rewinds
  // the pointers because the stale contents are never observable again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 4'd0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= '{pc: wr_pc, inst: wr_inst};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {3'b000, wr_en} - {3'b000, rd_en};
    end
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues imem reads, buffers returned words, holds the PC on lack of credit.
// Optional feature macro: FETCH_BUF_BYPASS_EN (presents a landing word straight to decode).
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_imem_raddr,
  output logic        o_imem_ren,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_flush,
  output logic        o_pc_hold,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  logic        req_vld_p0;
  logic [31:0] req_pc_p0;
  logic [31:0] head_pc;
  logic [31:0] head_inst;
  logic [3:0]  count;
  logic [3:0]  credit;
  logic        fifo_nonempty;
  logic        byp;
  logic        pop;
  logic        wr_en;
  logic        rd_en;

  assign fifo_nonempty = (count != 4'd0);

`ifdef FETCH_BUF_BYPASS_EN
  assign byp = !fifo_nonempty & req_vld_p0 & !i_flush;
`else
  assign byp = 1'b0;
`endif

  assign o_valid = (fifo_nonempty | byp) & !i_flush;
  assign pop     = o_valid & i_ready;
  assign o_inst  = byp ? i_imem_rdata : head_inst;
  assign o_pc    = byp ? req_pc_p0    : head_pc;

  // Occupancy after this edge if nothing new were issued; a fresh request is
  // allowed only while that leaves room for its data to land.
  assign credit     = count + {3'b000, req_vld_p0} - {3'b000, pop};
  assign o_pc_hold  = !i_flush & (credit >= 4'(DEPTH));
  assign o_imem_ren = i_rst_n & !o_pc_hold;

  assign wr_en = req_vld_p0 & !i_flush & !(byp & i_ready);
  assign rd_en = pop & fifo_nonempty;

  // Stage p0: request in flight. Hold is forced low during a flush, so the
  // branch target issued in that cycle is always captured here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_vld_p0 <= 1'b0;
      req_pc_p0  <= '0;
    end else begin
      req_vld_p0 <= o_imem_ren;
      req_pc_p0  <= i_imem_raddr;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .flush    (i_flush),
    .wr_en    (wr_en),
    .wr_pc    (req_pc_p0),
    .wr_inst  (i_imem_rdata),
    .rd_en    (rd_en),
    .head_pc  (head_pc),
    .head_inst(head_inst),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: acts as PC and a 1-cycle-latency instruction memory.
module tb_fetch_buffer;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_imem_raddr;
  logic        o_imem_ren;
  logic [31:0] i_imem_rdata;
  logic        i_flush;
  logic        o_pc_hold;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_inst;
  logic [31:0] o_pc;

  int   tests;
  int   fails;
  logic hold_s;

  fetch_buffer #(
    .DEPTH(2)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_imem_raddr(i_imem_raddr),
    .o_imem_ren  (o_imem_ren),
    .i_imem_rdata(i_imem_rdata),
    .i_flush     (i_flush),
    .o_pc_hold   (o_pc_hold),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_inst      (o_inst),
    .o_pc        (o_pc)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Synchronous instruction memory: mem[a] = 0xA000_0000 + a.
  initial i_imem_rdata = 32'd0;
  always @(posedge i_clk) begin
    if (o_imem_ren) i_imem_rdata <= 32'hA000_0000 + i_imem_raddr;
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // PC behaviour: advance by 4 after every cycle it was not halted.
  task automatic next_cycle();
    hold_s = o_pc_hold;
    @(posedge i_clk);
    #1;
    if (!hold_s && i_rst_n) i_imem_raddr = i_imem_raddr + 32'd4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tests        = 0;
    fails        = 0;
    i_rst_n      = 1'b0;
    i_imem_raddr = 32'd0;
    i_flush      = 1'b0;
    i_ready      = 1'b0;

    @(negedge i_clk);
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_hold", o_pc_hold, 1'b0);
    chk1("rst_ren", o_imem_ren, 1'b0);
    chk32("rst_pc", o_pc, 32'd0);
    chk32("rst_inst", o_inst, 32'd0);

    // Streaming from address 0 with decode always ready.
    next_cycle();
    i_rst_n = 1'b1; i_imem_raddr = 32'h0; i_ready = 1'b1;
    @(negedge i_clk);
    chk1("c0_ren", o_imem_ren, 1'b1);
    chk1("c0_valid", o_valid, 1'b0);
    next_cycle(); @(negedge i_clk);
    chk1("c1_valid", o_valid, 1'b0);
    chk1("c1_hold", o_pc_hold, 1'b0);
    next_cycle(); @(negedge i_clk);
    chk1("c2_valid", o_valid, 1'b1);
    chk32("c2_pc", o_pc, 32'h0);
    chk32("c2_inst", o_inst, 32'hA000_0000);
    chk1("c2_hold", o_pc_hold, 1'b0);
    next_cycle(); @(negedge i_clk);
    chk32("c3_pc", o_pc, 32'h4);
    chk1("c3_hold", o_pc_hold, 1'b0);
    next_cycle(); @(negedge i_clk);
    chk32("c4_pc", o_pc, 32'h8);
    chk32("c4_inst", o_inst, 32'hA000_0008);

    // Backpressure.
    next_cycle(); i_ready = 1'b0; @(negedge i_clk);
    chk32("c5_pc", o_pc, 32'hC);
    chk1("c5_hold", o_pc_hold, 1'b1);
    chk1("c5_ren", o_imem_ren, 1'b0);
    next_cycle(); @(negedge i_clk);
    chk1("c6_hold", o_pc_hold, 1'b1);
    chk32("c6_pc", o_pc, 32'hC);
    next_cycle(); i_ready = 1'b1; @(negedge i_clk);
    chk32("c7_pc", o_pc, 32'hC);
    chk1("c7_hold", o_pc_hold, 1'b0);
    next_cycle(); @(negedge i_clk);
    chk32("c8_pc", o_pc, 32'h10);
    chk1("c8_valid", o_valid, 1'b1);
    next_cycle(); @(negedge i_clk);
    chk32("c9_pc", o_pc, 32'h14);

    // Flush with a buffered entry and a request in flight.
    next_cycle(); i_flush = 1'b1; i_imem_raddr = 32'h40; @(negedge i_clk);
    chk1("c10_valid", o_valid, 1'b0);
    chk1("c10_hold", o_pc_hold, 1'b0);
    chk1("c10_ren", o_imem_ren, 1'b1);
    next_cycle(); i_flush = 1'b0; @(negedge i_clk);
    chk1("c11_valid", o_valid, 1'b0);
    next_cycle(); @(negedge i_clk);
    chk1("c12_valid", o_valid, 1'b1);
    chk32("c12_pc", o_pc, 32'h40);
    chk32("c12_inst", o_inst, 32'hA000_0040);

    // Back-to-back flushes.
    next_cycle(); i_flush = 1'b1; i_imem_raddr = 32'h40; @(negedge i_clk);
    chk1("c13_valid", o_valid, 1'b0);
    next_cycle(); i_imem_raddr = 32'h80; @(negedge i_clk);
    chk1("c14_valid", o_valid, 1'b0);
    next_cycle(); i_flush = 1'b0; @(negedge i_clk);
    chk1("c15_valid", o_valid, 1'b0);
    next_cycle(); @(negedge i_clk);
    chk1("c16_valid", o_valid, 1'b1);
    chk32("c16_pc", o_pc, 32'h80);
    chk32("c16_inst", o_inst, 32'hA000_0080);

    // Fill to two entries, then reset mid-stream.
    next_cycle(); i_ready = 1'b0; @(negedge i_clk);
    chk32("c17_pc", o_pc, 32'h84);
    chk1("c17_hold", o_pc_hold, 1'b1);
    next_cycle(); @(negedge i_clk);
    chk1("c18_valid", o_valid, 1'b1);
    chk1("c18_hold", o_pc_hold, 1'b1);
    i_rst_n = 1'b0;
    #1;
    chk1("mrst_valid", o_valid, 1'b0);
    chk1("mrst_hold", o_pc_hold, 1'b0);
    chk1("mrst_ren", o_imem_ren, 1'b0);
    chk32("mrst_pc", o_pc, 32'd0);
    chk32("mrst_inst", o_inst, 32'd0);

    next_cycle(); i_rst_n = 1'b1; i_imem_raddr = 32'h10; i_ready = 1'b1; @(negedge i_clk);
    chk1("r0_ren", o_imem_ren, 1'b1);
    chk1("r0_valid", o_valid, 1'b0);
    next_cycle(); @(negedge i_clk);
`ifdef FETCH_BUF_BYPASS_EN
    chk1("r1_valid", o_valid, 1'b1);
    chk32("r1_pc", o_pc, 32'h10);
    chk32("r1_inst", o_inst, 32'hA000_0010);
    next_cycle(); @(negedge i_clk);
    chk1("r2_valid", o_valid, 1'b1);
    chk32("r2_pc", o_pc, 32'h14);
`else
    chk1("r1_valid", o_valid, 1'b0);
    next_cycle(); @(negedge i_clk);
    chk1("r2_valid", o_valid, 1'b1);
    chk32("r2_pc", o_pc, 32'h10);
    chk32("r2_inst", o_inst, 32'hA000_0010);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
